// File: rtl/shot_resolver.sv
// Multi-player board engine: ship placement, shot resolution against the next
// player, ship-cell accounting, turn rotation, winner detection and a
// registered display readout port.
module shot_resolver #(
  parameter int BOARD_SIZE  = 10,
  parameter int NUM_PLAYERS = 2,
  parameter int SHIP_CELLS  = 17,
  localparam int CW = $clog2(BOARD_SIZE),
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int NW = $clog2(SHIP_CELLS + 1)
) (
  input  logic                      clock50,
  input  logic                      reset,
  input  logic                      place_valid,
  input  logic [PW-1:0]             place_player,
  input  logic [CW-1:0]             place_row,
  input  logic [CW-1:0]             place_col,
  input  logic                      start,
  input  logic                      fire_valid,
  input  logic [CW-1:0]             fire_row,
  input  logic [CW-1:0]             fire_col,
  input  logic                      new_game,
  input  logic [PW-1:0]             read_player,
  input  logic [CW-1:0]             read_row,
  input  logic [CW-1:0]             read_col,
  input  logic                      read_fog,
  output logic [1:0]                read_cell,
  output logic                      ready,
  output logic [PW-1:0]             turn,
  output logic                      result_valid,
  output logic [1:0]                result_code,
  output logic                      place_err,
  output logic                      game_over,
  output logic [PW-1:0]             winner,
  output logic [NUM_PLAYERS*NW-1:0] remaining
);

  // Storage spans the full index range so any coordinate code selects a real
  // entry; cells outside BOARD_SIZE / NUM_PLAYERS are never written.
  localparam int BD = 1 << CW;
  localparam int NP = 1 << PW;
  localparam logic [CW:0]   BS_LIM = (CW+1)'(BOARD_SIZE);
  localparam logic [PW:0]   NP_LIM = (PW+1)'(NUM_PLAYERS);
  localparam logic [NW-1:0] FULL   = NW'(SHIP_CELLS);
  localparam logic [PW-1:0] LAST   = PW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {SETUP, READY, RESOLVE, OVER} state_t;

  state_t        state, state_next;
  logic [1:0]    cells [NP][BD][BD];
  logic [NW-1:0] count [NP];
  logic [CW-1:0] shot_row, shot_col;

  logic [PW-1:0] tgt;
  logic [1:0]    tcell, res_code_next, res_cell, read_next;
  logic          place_in, shot_in, all_full;
  logic          place_ok, err_next, start_ok, shot_take;
  logic          res_valid_next, res_write, sink, advance, win, clear;

  assign ready     = (state == READY);
  assign game_over = (state == OVER);

  // Per-player ship counts packed onto the remaining bus.
  always_comb begin
    remaining = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++)
      remaining[p*NW +: NW] = count[PW'(p)];
  end

  // Next-state decode and datapath control for placement, start and shots.
  always_comb begin
    state_next     = state;
    place_ok       = 1'b0;
    err_next       = 1'b0;
    start_ok       = 1'b0;
    shot_take      = 1'b0;
    res_valid_next = 1'b0;
    res_code_next  = 2'b00;
    res_write      = 1'b0;
    res_cell       = 2'b00;
    sink           = 1'b0;
    advance        = 1'b0;
    win            = 1'b0;
    clear          = 1'b0;

    tgt      = (turn == LAST) ? '0 : turn + 1'b1;
    tcell    = cells[tgt][shot_row][shot_col];
    shot_in  = ({1'b0, shot_row} < BS_LIM) && ({1'b0, shot_col} < BS_LIM);
    place_in = ({1'b0, place_row} < BS_LIM) && ({1'b0, place_col} < BS_LIM) &&
               ({1'b0, place_player} < NP_LIM);
    all_full = 1'b1;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++)
      if (count[PW'(p)] != FULL) all_full = 1'b0;

    unique case (state)
      SETUP: begin
        if (place_valid) begin
          if (place_in && cells[place_player][place_row][place_col] == 2'b00 &&
              count[place_player] < FULL)
            place_ok = 1'b1;
          else
            err_next = 1'b1;
        end
        if (start) begin
          if (all_full) begin
            start_ok   = 1'b1;
            state_next = READY;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      READY: begin
        if (fire_valid) begin
          shot_take  = 1'b1;
          state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        res_valid_next = 1'b1;
        state_next     = READY;
        if (!shot_in || tcell[1]) begin
          res_code_next = 2'b10;
        end else if (tcell == 2'b00) begin
          res_write     = 1'b1;
          res_cell      = 2'b10;
          advance       = 1'b1;
          res_code_next = 2'b00;
        end else begin
          res_write = 1'b1;
          res_cell  = 2'b11;
          sink      = 1'b1;
          if (count[tgt] <= NW'(1)) begin
            res_code_next = 2'b11;
            win           = 1'b1;
            state_next    = OVER;
          end else begin
            res_code_next = 2'b01;
            advance       = 1'b1;
          end
        end
      end
      OVER: begin
        if (new_game) begin
          clear      = 1'b1;
          state_next = SETUP;
        end
      end
      default: state_next = SETUP;
    endcase
  end

  // State register.
  always_ff @(posedge clock50) begin
    if (reset) state <= SETUP;
    else       state <= state_next;
  end

  // Boards, counts, turn, winner, shot latch and result/error pulses.
  always_ff @(posedge clock50) begin
    if (reset || clear) begin
      for (int unsigned p = 0; p < NP; p++) begin
        count[PW'(p)] <= '0;
        for (int unsigned r = 0; r < BD; r++)
          for (int unsigned c = 0; c < BD; c++)
            cells[PW'(p)][CW'(r)][CW'(c)] <= 2'b00;
      end
      turn   <= '0;
      winner <= '0;
    end else begin
      if (place_ok) begin
        cells[place_player][place_row][place_col] <= 2'b01;
        count[place_player] <= count[place_player] + 1'b1;
      end
      if (start_ok) turn <= '0;
      if (shot_take) begin
        shot_row <= fire_row;
        shot_col <= fire_col;
      end
      if (res_write) cells[tgt][shot_row][shot_col] <= res_cell;
      if (sink && count[tgt] != '0) count[tgt] <= count[tgt] - 1'b1;
      if (advance) turn <= tgt;
      if (win) winner <= turn;
    end

    if (reset) begin
      result_valid <= 1'b0;
      result_code  <= 2'b00;
      place_err    <= 1'b0;
      shot_row     <= '0;
      shot_col     <= '0;
    end else begin
      result_valid <= res_valid_next;
      place_err    <= err_next;
      if (res_valid_next) result_code <= res_code_next;
    end
  end

  // Readout selection: out-of-range coordinates give water, fog hides ships.
  always_comb begin
    read_next = cells[read_player][read_row][read_col];
    if (!(({1'b0, read_row} < BS_LIM) && ({1'b0, read_col} < BS_LIM) &&
          ({1'b0, read_player} < NP_LIM)))
      read_next = 2'b00;
    else if (read_fog && read_next == 2'b01)
      read_next = 2'b00;
  end

  // Registered readout port.
  always_ff @(posedge clock50) begin
    if (reset) read_cell <= 2'b00;
    else       read_cell <= read_next;
  end

endmodule

// File: tb/tb_shot_resolver.sv
// Bench for shot_resolver: a 2-player 10x10 instance driven by randomized
// placement and play against a board-level reference model, plus a 3-player
// 8x8 instance for turn rotation and reset during shot resolution.
`timescale 1ns/1ps
module tb_shot_resolver;

  logic clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  // 2-player, 10x10, 17 ship cells
  logic       reset, place_valid, start, fire_valid, new_game, read_fog;
  logic [0:0] place_player, read_player, turn, winner;
  logic [3:0] place_row, place_col, fire_row, fire_col, read_row, read_col;
  logic [1:0] read_cell, result_code;
  logic       ready, result_valid, place_err, game_over;
  logic [9:0] remaining;

  // 3-player, 8x8, 2 ship cells
  logic       t3_reset, t3_place_valid, t3_start, t3_fire_valid, t3_new_game, t3_read_fog;
  logic [1:0] t3_place_player, t3_read_player, t3_turn, t3_winner;
  logic [2:0] t3_place_row, t3_place_col, t3_fire_row, t3_fire_col, t3_read_row, t3_read_col;
  logic [1:0] t3_read_cell, t3_result_code;
  logic       t3_ready, t3_result_valid, t3_place_err, t3_game_over;
  logic [5:0] t3_remaining;

  shot_resolver #(.BOARD_SIZE(10), .NUM_PLAYERS(2), .SHIP_CELLS(17)) dut (
    .clock50(clock50), .reset(reset),
    .place_valid(place_valid), .place_player(place_player),
    .place_row(place_row), .place_col(place_col), .start(start),
    .fire_valid(fire_valid), .fire_row(fire_row), .fire_col(fire_col),
    .new_game(new_game), .read_player(read_player), .read_row(read_row),
    .read_col(read_col), .read_fog(read_fog), .read_cell(read_cell),
    .ready(ready), .turn(turn), .result_valid(result_valid),
    .result_code(result_code), .place_err(place_err), .game_over(game_over),
    .winner(winner), .remaining(remaining));

  shot_resolver #(.BOARD_SIZE(8), .NUM_PLAYERS(3), .SHIP_CELLS(2)) dut3 (
    .clock50(clock50), .reset(t3_reset),
    .place_valid(t3_place_valid), .place_player(t3_place_player),
    .place_row(t3_place_row), .place_col(t3_place_col), .start(t3_start),
    .fire_valid(t3_fire_valid), .fire_row(t3_fire_row), .fire_col(t3_fire_col),
    .new_game(t3_new_game), .read_player(t3_read_player), .read_row(t3_read_row),
    .read_col(t3_read_col), .read_fog(t3_read_fog), .read_cell(t3_read_cell),
    .ready(t3_ready), .turn(t3_turn), .result_valid(t3_result_valid),
    .result_code(t3_result_code), .place_err(t3_place_err), .game_over(t3_game_over),
    .winner(t3_winner), .remaining(t3_remaining));

  // Reference model of the 2-player game: boards, counts, turn, phase
  int brd [2][16][16];
  int cnt [2];
  int m_turn, m_win, m_phase;   // phase: 0 setup, 1 play, 2 over
  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock50);
    #1;
  endtask

  function automatic void model_clear();
    for (int p = 0; p < 2; p++) begin
      cnt[p] = 0;
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) brd[p][r][c] = 0;
    end
    m_turn = 0; m_win = 0; m_phase = 0;
  endfunction

  function automatic int model_place(int p, int r, int c);
    if (m_phase != 0) return 0;
    if (r < 10 && c < 10 && brd[p][r][c] == 0 && cnt[p] < 17) begin
      brd[p][r][c] = 1;
      cnt[p]++;
      return 0;
    end
    return 1;
  endfunction

  function automatic int model_fire(int r, int c);
    int t;
    t = (m_turn + 1) % 2;
    if (r >= 10 || c >= 10 || brd[t][r][c] >= 2) return 2;
    if (brd[t][r][c] == 0) begin
      brd[t][r][c] = 2;
      m_turn = t;
      return 0;
    end
    brd[t][r][c] = 3;
    cnt[t]--;
    if (cnt[t] == 0) begin
      m_phase = 2;
      m_win = m_turn;
      return 3;
    end
    m_turn = t;
    return 1;
  endfunction

  function automatic int exp_rem();
    return cnt[0] + cnt[1] * 32;
  endfunction

  task automatic do_place(input int p, input int r, input int c);
    int e;
    place_valid = 1'b1; place_player = 1'(p); place_row = 4'(r); place_col = 4'(c);
    cyc();
    place_valid = 1'b0;
    e = model_place(p, r, c);
    check("place_err", place_err, e);
  endtask

  task automatic do_start();
    int e;
    start = 1'b1;
    cyc();
    start = 1'b0;
    e = 0;
    if (m_phase == 0) begin
      if (cnt[0] == 17 && cnt[1] == 17) begin m_phase = 1; m_turn = 0; end
      else e = 1;
    end
    check("start_err", place_err, e);
    check("ready", ready, m_phase == 1);
    check("turn_start", turn, m_turn);
  endtask

  task automatic do_fire(input int r, input int c);
    int e;
    fire_valid = 1'b1; fire_row = 4'(r); fire_col = 4'(c);
    cyc();
    fire_valid = 1'b0;
    check("rv_early", result_valid, 0);
    cyc();
    if (m_phase == 1) begin
      e = model_fire(r, c);
      check("rv", result_valid, 1);
      check("code", result_code, e);
    end else begin
      check("rv_ignored", result_valid, 0);
    end
    check("turn", turn, m_turn);
    check("remaining", remaining, exp_rem());
    check("game_over", game_over, m_phase == 2);
    check("ready_fire", ready, m_phase == 1);
  endtask

  task automatic do_read(input int p, input int r, input int c, input int f);
    int v;
    read_player = 1'(p); read_row = 4'(r); read_col = 4'(c); read_fog = f[0];
    cyc();
    v = (r < 10 && c < 10) ? brd[p][r][c] : 0;
    if (f != 0 && v == 1) v = 0;
    check("read_cell", read_cell, v);
  endtask

  task automatic fill(input int p, input int target);
    int r, c;
    for (int g = 0; g < 3000 && cnt[p] < target; g++) begin
      r = $urandom_range(0, 10);
      c = $urandom_range(0, 10);
      if (!(p == 0 && r == 0 && c == 0)) do_place(p, r, c);
    end
    check("fill_count", cnt[p], target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, found, k;
    {place_valid, start, fire_valid, new_game, read_fog} = '0;
    {place_player, read_player, place_row, place_col, fire_row, fire_col, read_row, read_col} = '0;
    {t3_place_valid, t3_start, t3_fire_valid, t3_new_game, t3_read_fog} = '0;
    {t3_place_player, t3_read_player, t3_place_row, t3_place_col} = '0;
    {t3_fire_row, t3_fire_col, t3_read_row, t3_read_col} = '0;
    reset = 1'b1; t3_reset = 1'b1;
    model_clear();
    cyc(); cyc();
    check("rst_ready", ready, 0);
    check("rst_turn", turn, 0);
    check("rst_rv", result_valid, 0);
    check("rst_code", result_code, 0);
    check("rst_perr", place_err, 0);
    check("rst_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_rem", remaining, 0);
    check("rst_read", read_cell, 0);
    reset = 1'b0;
    cyc();

    // Placement, including the 16-cell start, duplicate and 18th-cell errors
    do_place(1, 3, 4);
    fill(0, 17);
    fill(1, 16);
    do_start();
    do_place(1, 3, 4);
    fill(1, 17);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++)
      if (brd[1][i / 10][i % 10] == 0) begin found = 1; r = i / 10; c = i % 10; end
    do_place(1, r, c);
    do_read(1, 3, 4, 0);
    do_read(1, 3, 4, 1);
    do_read(0, 12, 3, 0);
    do_start();
    check("rem_full", remaining, 17 + 17 * 32);

    // Directed shots
    do_fire(3, 4);
    do_read(1, 3, 4, 0);
    do_fire(0, 0);
    do_read(0, 0, 0, 1);
    do_fire(3, 4);
    do_fire(10, 2);

    // fire_valid held into RESOLVE produces exactly one result
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++)
      if (brd[1][i / 10][i % 10] == 1) begin found = 1; r = i / 10; c = i % 10; end
    fire_valid = 1'b1; fire_row = 4'(r); fire_col = 4'(c);
    cyc();
    check("rv_resolve", result_valid, 0);
    cyc();
    fire_valid = 1'b0;
    k = model_fire(r, c);
    check("rv_held", result_valid, 1);
    check("code_held", result_code, k);
    cyc();
    check("rv_extra1", result_valid, 0);
    cyc();
    check("rv_extra2", result_valid, 0);
    check("turn_held", turn, m_turn);

    // Randomized play until someone wins; player 0 mostly targets live ships
    for (int it = 0; it < 300 && m_phase == 1; it++) begin
      r = $urandom_range(0, 10);
      c = $urandom_range(0, 10);
      if (m_turn == 0 && $urandom_range(0, 3) != 0) begin
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++)
          if (brd[1][i / 10][i % 10] == 1) begin found = 1; r = i / 10; c = i % 10; end
      end
      do_fire(r, c);
      do_read($urandom_range(0, 1), $urandom_range(0, 10), $urandom_range(0, 10),
              $urandom_range(0, 1));
    end
    check("game_over_end", game_over, 1);
    check("winner", winner, m_win);

    // OVER ignores everything but new_game
    do_fire(5, 5);
    do_place(0, 9, 9);
    do_start();
    check("winner_hold", winner, m_win);
    new_game = 1'b1;
    cyc();
    new_game = 1'b0;
    model_clear();
    check("ng_over", game_over, 0);
    check("ng_ready", ready, 0);
    check("ng_turn", turn, 0);
    check("ng_winner", winner, 0);
    check("ng_rem", remaining, 0);
    do_read(1, 3, 4, 0);
    do_read(0, 0, 0, 0);
    do_read(1, 0, 0, 0);
    do_place(0, 5, 5);

    // 3-player instance: rotation and targets
    t3_reset = 1'b0;
    cyc();
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 2; j++) begin
        t3_place_valid = 1'b1; t3_place_player = 2'(p);
        t3_place_row = 3'(j); t3_place_col = 3'(j);
        cyc();
        t3_place_valid = 1'b0;
        check("t3_place_err", t3_place_err, 0);
      end
    t3_start = 1'b1;
    cyc();
    t3_start = 1'b0;
    check("t3_ready", t3_ready, 1);
    check("t3_turn0", t3_turn, 0);
    check("t3_rem", t3_remaining, 2 + 2 * 4 + 2 * 16);
    for (int s = 0; s < 3; s++) begin
      t3_fire_valid = 1'b1; t3_fire_row = 3'd7; t3_fire_col = 3'(s);
      cyc();
      t3_fire_valid = 1'b0;
      check("t3_rv_early", t3_result_valid, 0);
      cyc();
      check("t3_rv", t3_result_valid, 1);
      check("t3_code", t3_result_code, 0);
      check("t3_turn", t3_turn, (s + 1) % 3);
      t3_read_player = 2'((s + 1) % 3); t3_read_row = 3'd7; t3_read_col = 3'(s);
      cyc();
      check("t3_tgt_cell", t3_read_cell, 2);
      t3_read_player = 2'((s + 2) % 3);
      cyc();
      check("t3_other_cell", t3_read_cell, 0);
    end
    t3_fire_valid = 1'b1; t3_fire_row = 3'd0; t3_fire_col = 3'd0;
    cyc();
    t3_fire_valid = 1'b0;
    cyc();
    check("t3_hit", t3_result_code, 1);
    check("t3_turn_hit", t3_turn, 1);
    check("t3_rem_hit", t3_remaining, 2 + 1 * 4 + 2 * 16);

    // Reset while a shot is in RESOLVE
    t3_read_player = 2'd2; t3_read_row = 3'd1; t3_read_col = 3'd1; t3_read_fog = 1'b0;
    t3_fire_valid = 1'b1; t3_fire_row = 3'd0; t3_fire_col = 3'd0;
    cyc();
    t3_fire_valid = 1'b0;
    t3_reset = 1'b1;
    cyc();
    check("t3r_rv", t3_result_valid, 0);
    check("t3r_ready", t3_ready, 0);
    check("t3r_turn", t3_turn, 0);
    check("t3r_code", t3_result_code, 0);
    check("t3r_rem", t3_remaining, 0);
    check("t3r_over", t3_game_over, 0);
    check("t3r_winner", t3_winner, 0);
    check("t3r_perr", t3_place_err, 0);
    check("t3r_read", t3_read_cell, 0);
    t3_reset = 1'b0;
    cyc();
    check("t3r_rv_after", t3_result_valid, 0);
    check("t3r_read_after", t3_read_cell, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shot_resolver.md
Name: shot_resolver

Overview:
- Parametrised game-state engine holding every player's board as 2-bit cells: 00 water, 01 ship, 10 miss, 11 hit.
- Handles ship placement, validates and resolves shots against the next player, counts remaining ship cells, rotates the turn and detects the winner.
- Sits between the keyboard decode (row/col/enter strobes) and the VGA/HEX display paths, which read cells through a registered read port.

Parameters:
- BOARD_SIZE, 10: board is BOARD_SIZE x BOARD_SIZE cells; legal range 2..16.
- NUM_PLAYERS, 2: number of players; legal range 2..4.
- SHIP_CELLS, 17: ship cells each player must place before play.
- Derived: CW = clog2(BOARD_SIZE); PW = max(1, clog2(NUM_PLAYERS)); NW = clog2(SHIP_CELLS+1).

Ports:
- clock50  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- place_valid  in  1  one-cycle strobe: place one ship cell.
- place_player  in  PW  board that receives the placed cell.
- place_row, place_col  in  CW each  placement coordinate.
- start  in  1  one-cycle strobe: leave SETUP.
- fire_valid  in  1  one-cycle strobe: current player fires.
- fire_row, fire_col  in  CW each  shot coordinate.
- new_game  in  1  one-cycle strobe in OVER: return to SETUP.
- read_player  in  PW  board selected for display readout.
- read_row, read_col  in  CW each  readout coordinate.
- read_fog  in  1  1 = opponent view; ship cells read as water.
- read_cell  out  2  registered cell value.
- ready  out  1  high only in READY.
- turn  out  PW  current shooter.
- result_valid  out  1  one-cycle pulse per resolved shot.
- result_code  out  2  00 miss, 01 hit, 10 reject, 11 win.
- place_err  out  1  one-cycle pulse on a rejected placement or start.
- game_over  out  1  high in OVER.
- winner  out  PW  winning player; valid while game_over is high.
- remaining  out  NUM_PLAYERS*NW  ship cells left per player; player p occupies bits [p*NW +: NW].

Behaviour:

Reset:
- All cells become 00, all counts become 0, state becomes SETUP.
- ready, turn, result_valid, result_code, place_err, game_over, winner and read_cell all become 0.

Target:
- tgt = (turn+1) mod NUM_PLAYERS.

SETUP state:
- A placement is accepted when place_valid is high, the coordinate is below BOARD_SIZE, the cell is 00 and that player's count is below SHIP_CELLS.
- An accepted placement writes 01 and increments the player's count.
- A placement that fails any of those conditions leaves the board unchanged and pulses place_err on the next cycle.
- start is accepted only if every player's count equals SHIP_CELLS. It then moves the state to READY with turn = 0; otherwise it pulses place_err.
- fire_valid is ignored in SETUP.

READY state:
- When fire_valid is sampled at cycle T, the coordinate is latched and the state is RESOLVE at T+1.
- In RESOLVE the target cell is read.
- At T+2 the result is registered, result_valid pulses and the state leaves RESOLVE. RESOLVE always lasts exactly one cycle.
- Resolution rules:
  - Out-of-range coordinate, or target cell already 10/11: code 10; no write; turn unchanged.
  - Cell 00: written to 10; code 00; turn advances.
  - Cell 01: written to 11; target count decrements; turn advances, giving code 01. If the count reaches 0, code is 11, winner = turn, game_over = 1, state = OVER, and turn holds.

Ignored inputs:
- fire_valid while ready is low (RESOLVE, SETUP, OVER) is ignored; no result is produced.
- place_valid and start outside SETUP are ignored; place_err is not pulsed.

OVER state:
- All input strobes are ignored except new_game.
- new_game clears the boards, counts, turn, winner and game_over and returns to SETUP on the next cycle.

Readout:
- read_cell is updated every cycle from the inputs sampled in the previous cycle (1-cycle latency).
- An out-of-range readout coordinate returns 00.
- When read_fog is high, 01 is returned as 00.
- A write performed at edge E is visible in read_cell one cycle after a read sampled at or after E.

Simultaneous events and arithmetic:
- reset has priority over every input. A reset during RESOLVE produces no result_valid.
- Counts saturate at 0 and at SHIP_CELLS; no wrap-around.
- The turn advance wraps from NUM_PLAYERS-1 to 0.

Test Plan:
- Place 17 distinct cells for both players, then pulse start -> ready = 1 at the next cycle, turn = 0, remaining = {17,17}.
- With player 1 holding a ship at (3,4): P0 fires at (3,4) -> result_code 01 two cycles later, remaining[1] = 16, turn = 1, and read_cell for (p1,3,4) = 11.
- P1 fires at water (0,0) -> code 00, cell = 10, turn = 0. P0 repeats its shot at (3,4) -> code 10, turn stays 0. P0 fires at row 10 -> code 10.
- Pulse fire_valid on the cycle after an accepted shot (state RESOLVE) -> no extra result_valid. Place a duplicate cell, an 18th cell, or pulse start with only 16 cells placed -> place_err pulse, state unchanged.
- Sink player 1's last ship cell -> code 11, game_over = 1, winner = 0. Further fire_valid -> no response. new_game -> SETUP with all cells reading 00.
- With NUM_PLAYERS = 3 and BOARD_SIZE = 8: turn sequence 0 -> 1 -> 2 -> 0, targets 1, 2, 0. Asserting reset in RESOLVE -> no result_valid, and all outputs return to their reset values at the next edge.
